// File: rtl/serial_add_sub.sv
`default_nettype none
//============================================================================
// Module   : serial_add_sub
// Purpose  : Bit-serial adder/subtractor. Operands are captured over a
//            valid/ready handshake, processed LSB first through a single
//            full add/sub cell with a registered carry/borrow (one bit per
//            clock), and the result is returned over a second valid/ready
//            handshake.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_valid, in_ready  - operand handshake
//            a, b, sub           - operands, mode (0: a+b, 1: a-b)
//            out_valid,out_ready - result handshake
//            result              - sum/difference modulo 2^WIDTH
//            carry_borrow        - add: carry out; sub: a < b (unsigned)
//            overflow            - two's-complement signed overflow
// Config   : `define SERIAL_ADD_SUB_OVF_EN to build the overflow detector;
//            without it the overflow port is tied to 0.
// Revision : 1.0 - initial release
//============================================================================
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_borrow,
    output logic             overflow
);

    localparam int                 c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_sub;
    logic               r_carry;
    logic               r_cb;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_ai;
    logic               w_bi;
    logic               w_sum;
    logic               w_carry_nxt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Held low during reset so nothing is accepted while the
                // block is being cleared.
                in_ready = ~rst;
                if (in_valid && ~rst) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == c_cnt_last) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Single full add/sub cell working on the current LSBs
    // ------------------------------------------------------------------
    assign w_ai  = r_a[0];
    assign w_bi  = r_b[0];
    assign w_sum = w_ai ^ w_bi ^ r_carry;

    always_comb begin
        if (r_sub) begin
            w_carry_nxt = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_carry);
        end else begin
            w_carry_nxt = (w_ai & w_bi) | ((w_ai ^ w_bi) & r_carry);
        end
    end

    // ------------------------------------------------------------------
    // Operand shifters, result shifter, carry FF and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_cb    <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= sub;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            // Bits enter at the MSB so after WIDTH shifts bit 0 sits at LSB.
            r_res   <= {w_sum, r_res[WIDTH-1:1]};
            r_carry <= w_carry_nxt;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cb <= w_carry_nxt;
            end
        end
    end

    assign result       = r_res;
    assign carry_borrow = r_cb;

`ifdef SERIAL_ADD_SUB_OVF_EN
    // On the last bit the cell sees the operand sign bits and produces the
    // result sign bit, so overflow is decided from those three bits alone.
    logic r_ovf;
    logic w_ovf_nxt;

    assign w_ovf_nxt = (r_sub ? (w_ai ^ w_bi) : ~(w_ai ^ w_bi)) & (w_sum ^ w_ai);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= w_ovf_nxt;
        end
    end

    assign overflow = r_ovf;
`else
    assign overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
//============================================================================
// Module   : tb_serial_add_sub
// Purpose  : Scoreboard bench for serial_add_sub: directed known-answer
//            cases, backpressure, mid-operation reset and a randomized
//            sweep against an arithmetic reference model.
// Revision : 1.0 - initial release
//============================================================================
module tb_serial_add_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_borrow;
    logic         overflow;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .sub          (sub),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .carry_borrow (carry_borrow),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cb;
        logic         ovf;
        logic [31:0]  acc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   rand_bp  = 0;
    logic or_force = 1'b1;

`ifdef SERIAL_ADD_SUB_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input int acc);
        exp_t   e;
        longint ux, uy, sx, sy, t, st;
        ux = longint'(x);
        uy = longint'(y);
        sx = x[W-1] ? ux - (longint'(1) << W) : ux;
        sy = y[W-1] ? uy - (longint'(1) << W) : uy;
        t  = s ? ux - uy : ux + uy;
        st = s ? sx - sy : sx + sy;
        e.res = t[W-1:0];
        e.cb  = s ? (ux < uy) : (t >= (longint'(1) << W));
        e.ovf = OVF_ON & ((st > ((longint'(1) << (W-1)) - 1)) ||
                          (st < -(longint'(1) << (W-1))));
        e.acc = acc;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single driver of out_ready, applied slightly after the main process.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : or_force;
        end
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        exp_t e;
        logic prev_ov = 1'b0;
        int   vstart  = 0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev_ov) vstart = cyc;
            prev_ov = out_valid;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got result %0h with empty scoreboard", result);
                end else begin
                    e = sb.pop_front();
                    chk("result", 64'(result), 64'(e.res));
                    chk("carry_borrow", 64'(carry_borrow), 64'(e.cb));
                    chk("overflow", 64'(overflow), 64'(e.ovf));
                    chk("latency", 64'(vstart - int'(e.acc)), 64'(W));
                end
            end
        end
    end

    // Issue one operation; operands are scrambled while the op is in flight.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout: got in_ready=0 expected 1");
            return;
        end
        in_valid = 1'b1;
        a = x;
        b = y;
        sub = s;
        sb.push_back(model(x, y, s, cyc + 1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < W - 1; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            sub = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL out_valid_timeout: got out_valid=0 expected 1");
        end
    endtask

    task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                            input logic [W-1:0] er, input logic ecb, input logic eovf);
        do_op(x, y, s);
        wait_valid();
        chk("kat_result", 64'(result), 64'(er));
        chk("kat_carry_borrow", 64'(carry_borrow), 64'(ecb));
        chk("kat_overflow", 64'(overflow), 64'(eovf & OVF_ON));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] snap_res;
        logic         snap_cb, snap_ovf;
        bit           stable, rdy_low, never_valid;
        int           n;

        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_carry_borrow", 64'(carry_borrow), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Known answers
        directed(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        directed(8'h05, 8'h07, 1'b1, 8'hFE, 1'b1, 1'b0);
        directed(8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1);
        directed(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        directed(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);

        // Backpressure: DONE held for 20 cycles
        @(posedge clk);
        #1;
        or_force = 1'b0;
        do_op(8'h3C, 8'h5A, 1'b1);
        wait_valid();
        snap_res = result;
        snap_cb  = carry_borrow;
        snap_ovf = overflow;
        stable   = 1'b1;
        rdy_low  = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid || result !== snap_res || carry_borrow !== snap_cb ||
                overflow !== snap_ovf) stable = 1'b0;
            if (in_ready) rdy_low = 1'b0;
        end
        chk("bp_outputs_stable", 64'(stable), 64'd1);
        chk("bp_in_ready_low", 64'(rdy_low), 64'd1);
        @(posedge clk);
        #1;
        or_force = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);

        // Reset during bit 3 of SHIFT: op is discarded (not on scoreboard)
        in_valid = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        sub = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready_in_rst", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        never_valid = 1'b1;
        repeat (W + 4) begin
            @(negedge clk);
            if (out_valid) never_valid = 1'b0;
        end
        chk("abort_no_out_valid", 64'(never_valid), 64'd1);
        @(posedge clk);
        #1;
        directed(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

        // Randomized sweep with random backpressure
        rand_bp = 1;
        for (int i = 0; i < 1000; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom));
        end
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        rand_bp = 0;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial adder/subtractor: accepts two WIDTH-bit operands and a mode bit over a valid/ready handshake. It processes one bit per clock, LSB first, through a single full add/sub cell with a registered carry/borrow. It returns the result with carry/borrow and signed overflow over a second valid/ready handshake. It is the area-minimal, multi-cycle counterpart to the parallel combinational add/sub cells in the arithmetic library, intended for datapaths that trade latency for gates.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset; single clock, all state sampled on clk
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend/addend
- b  input  WIDTH  subtrahend/addend
- sub  input  1  0 = a+b, 1 = a−b
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  sum or difference, modulo 2^WIDTH
- carry_borrow  output  1  add: carry out of MSB; sub: 1 when a < b (unsigned)
- overflow  output  1  two's-complement signed overflow (see Configuration)

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture a, b, sub into shift registers; clear carry/borrow FF; clear bit counter; go to SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each cycle, compute bit i: add: s=a_i^b_i^c, c'=a_i&b_i | (a_i^b_i)&c. Sub: d=a_i^b_i^w, w'=~a_i&b_i | ~(a_i^b_i)&w.
  - Shift the bit into result MSB-side and advance the counter.
  - After the bit WIDTH−1 cycle, latch the final carry/borrow and overflow; go to DONE.
- DONE:
  - out_valid=1; result, carry_borrow and overflow are held stable.
  - On out_valid&&out_ready, go to IDLE.
- Operand inputs are ignored outside the IDLE accept cycle; changes during SHIFT/DONE have no effect.
- Overflow:
  - add: a[MSB]==b[MSB] && result[MSB]!=a[MSB]
  - sub: a[MSB]!=b[MSB] && result[MSB]!=a[MSB]
- Results are always correct modulo 2^WIDTH; no saturation.

## Timing
- Reset: after any clk edge with rst=1, state=IDLE and out_valid=0; result, carry_borrow, overflow = 0; counter and carry FF = 0. in_ready=0 while rst is high, and 1 from the first cycle after rst deasserts.
- Reset mid-operation (SHIFT or DONE) aborts silently; the pending result is discarded and no out_valid pulse occurs.
- Latency: operands accepted at edge k produce out_valid=1 in the cycle after edge k+WIDTH (WIDTH SHIFT cycles).
- Throughput: one operation per WIDTH+2 cycles minimum: accept edge, WIDTH SHIFT edges, out handshake edge, return to IDLE. in_ready is not asserted in DONE, so there is no back-to-back overlap.
- Backpressure: out_ready=0 holds DONE indefinitely with outputs stable. out_ready is ignored outside DONE.
- in_valid may be held high continuously; exactly one operation is accepted per IDLE visit.

## Configuration
- SERIAL_ADD_SUB_OVF_EN:
  - Defined: the overflow detection logic and register are compiled in, and overflow behaves as specified.
  - Undefined: that logic is removed, and the overflow port is tied to 0 in all states.
- The port list is identical in both builds.

## Test plan
- WIDTH=8, add 0x7F+0x01 -> result=0x80, carry_borrow=0, overflow=1, out_valid exactly 8 cycles after the accept edge.
- Sub 0x05−0x07 -> result=0xFE, carry_borrow=1, overflow=0. Sub 0x80−0x01 -> result=0x7F, carry_borrow=0, overflow=1.
- Add 0xFF+0x01 -> result=0x00, carry_borrow=1, overflow=0. Sub 0x00−0x00 -> result=0x00, carry_borrow=0, overflow=0.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> outputs stable, in_ready=0. Then pulse out_ready -> IDLE next cycle, in_ready=1. Toggle a/b during SHIFT -> result unaffected.
- Reset mid-SHIFT at bit 3 -> next cycle IDLE, in_ready=1, out_valid never asserts for the aborted op. A new op 0x10+0x20 -> 0x30.
- Build without SERIAL_ADD_SUB_OVF_EN: 0x7F+0x01 -> result=0x80, overflow=0. Random 1000-op sweep vs a reference model in both builds.
